// File: rtl/icache.sv
// icache -- direct-mapped instruction cache with single-line miss handling.
//
// Optional feature: define ICACHE_STATS_EN to add saturating hit/miss counters.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   req_valid/addr    fetch request (byte address, bits [1:0] ignored)
//   flush             squash the in-flight fetch (branch redirect)
//   stall             fetch must hold its PC (combinational)
//   instr_valid/instr delivered instruction, one cycle after hit or fill
//   mem_req/mem_addr  one-cycle line-fill request, line-aligned address
//   mem_resp_valid    fill data valid (only honoured while waiting for a fill)
//   mem_resp_data     full line, word 0 in LSBs
//   hit_count/miss_count  (ICACHE_STATS_EN only) saturating event counters
module icache #(
    parameter int unsigned NUM_LINES    = 4,
    parameter int unsigned LINE_WORDS   = 4,
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned REG_LEN      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [ADDRESS_BITS-1:0]    req_addr,
    input  logic                       flush,
    output logic                       stall,
    output logic                       instr_valid,
    output logic [REG_LEN-1:0]         instr,
    output logic                       mem_req,
    output logic [ADDRESS_BITS-1:0]    mem_addr,
    input  logic                       mem_resp_valid,
    input  logic [LINE_WORDS*32-1:0]   mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = ADDRESS_BITS - IDX_W - OFF_W - 2;
    localparam int unsigned WADR_W = ADDRESS_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        FILL
    } state_e;

    state_e                  state_q;
    logic [NUM_LINES-1:0]    valid_q;
    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [31:0]             data_q [NUM_LINES][LINE_WORDS];
    logic [WADR_W-1:0]       miss_addr_q;
    logic                    flushed_q;
    logic                    instr_valid_q;
    logic [REG_LEN-1:0]      instr_q;
    logic                    mem_req_q;
    logic [ADDRESS_BITS-1:0] mem_addr_q;

    // Byte-select bits carry no information for word fetches.
    logic [1:0] unused_byte_sel;
    assign unused_byte_sel = req_addr[1:0];

    // Request address fields.
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign req_off = req_addr[2 +: OFF_W];
    assign req_idx = req_addr[2 + OFF_W +: IDX_W];
    assign req_tag = req_addr[ADDRESS_BITS-1 -: TAG_W];

    // Latched miss address fields (word address, byte bits dropped).
    logic [OFF_W-1:0] miss_off;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    assign miss_off = miss_addr_q[0 +: OFF_W];
    assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag = miss_addr_q[WADR_W-1 -: TAG_W];

    // Tag lookup.
    logic        lookup_hit;
    logic [31:0] lookup_word;
    assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lookup_word = data_q[req_idx][req_off];

    // Stall covers the miss-detect cycle and the whole outstanding fill.
    assign stall = !rst && (((state_q == IDLE) && req_valid && !lookup_hit) ||
                            (state_q == MISS_REQ) || (state_q == MISS_WAIT));

    // A response only counts while the FSM is waiting for it.
    logic fill_we;
    assign fill_we = !rst && (state_q == MISS_WAIT) && mem_resp_valid;

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            miss_addr_q   <= '0;
            flushed_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (lookup_hit) begin
                            instr_q       <= REG_LEN'(lookup_word);
                            instr_valid_q <= !flush;
                        end else begin
                            miss_addr_q <= req_addr[ADDRESS_BITS-1:2];
                            mem_addr_q  <= {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
                            mem_req_q   <= 1'b1;
                            flushed_q   <= flush;
                            state_q     <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    flushed_q <= flushed_q | flush;
                    state_q   <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    flushed_q <= flushed_q | flush;
                    if (mem_resp_valid) begin
                        valid_q[miss_idx] <= 1'b1;
                        state_q           <= FILL;
                    end
                end
                FILL: begin
                    // Line was written last cycle; a flush anywhere in the miss squashes delivery.
                    instr_q       <= REG_LEN'(data_q[miss_idx][miss_off]);
                    instr_valid_q <= !(flushed_q | flush);
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage; replaces whatever the indexed line held before.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[miss_idx] <= miss_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_q[miss_idx][w] <= mem_resp_data[w*32 +: 32];
            end
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Saturating lookup counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if ((state_q == IDLE) && req_valid) begin
            if (lookup_hit) begin
                if (hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache -- self-checking bench for icache.
// Backing memory is a fixed function of the word address; a line-level
// valid/tag table predicts hit or miss for each fetch. Define ICACHE_STATS_EN
// to also check the counters.
module tb_icache;

    localparam int unsigned NUM_LINES  = 4;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
    localparam logic [31:0] PC_BOOT    = 32'h0000_1000;

    logic                     clk;
    logic                     rst;
    logic                     req_valid;
    logic [31:0]              req_addr;
    logic                     flush;
    logic                     stall;
    logic                     instr_valid;
    logic [31:0]              instr;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic                     mem_resp_valid;
    logic [LINE_WORDS*32-1:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0]              hit_count;
    logic [31:0]              miss_count;
`endif

    icache #(
        .NUM_LINES    (NUM_LINES),
        .LINE_WORDS   (LINE_WORDS),
        .ADDRESS_BITS (32),
        .REG_LEN      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .flush          (flush),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: which line holds which tag, plus pending output expectations.
    bit          ref_valid [NUM_LINES];
    int unsigned ref_tag   [NUM_LINES];
    int unsigned ref_hits;
    int unsigned ref_misses;
    bit          exp_iv;
    logic [31:0] exp_instr;
    bit          exp_mreq;
    logic [31:0] exp_maddr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [LINE_WORDS*32-1:0] line_of(input logic [31:0] a);
        logic [LINE_WORDS*32-1:0] r;
        logic [31:0] base;
        base = a - (a % LINE_BYTES);
        for (int w = 0; w < LINE_WORDS; w++) begin
            r[w*32 +: 32] = mem_word(base + 32'(w * 4));
        end
        return r;
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return ((a / 4) / LINE_WORDS) % NUM_LINES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return (a / 4) / (LINE_WORDS * NUM_LINES);
    endfunction

    // Advance to the next falling edge and check the registered outputs.
    task automatic tick();
        @(negedge clk);
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (exp_iv) check_eq("instr", instr, exp_instr);
        check_eq("mem_req", 32'(mem_req), 32'(exp_mreq));
        if (exp_mreq) check_eq("mem_addr", mem_addr, exp_maddr);
        exp_iv   = 1'b0;
        exp_mreq = 1'b0;
    endtask

    // Reset with competing inputs active; rst must win.
    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        req_valid      = 1'b1;
        flush          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {LINE_WORDS{32'hDEAD_BEEF}};
        @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        rst            = 1'b0;
        req_valid      = 1'b0;
        flush          = 1'b0;
        mem_resp_valid = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        exp_iv     = 1'b0;
        exp_mreq   = 1'b0;
    endtask

    task automatic idle_cycle();
        tick();
        req_valid      = 1'b0;
        flush          = 1'($urandom_range(0, 1));
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
        #1 check_eq("idle_stall", 32'(stall), 32'd0);
    endtask

    // One fetch; PC is held (req_valid stays up) while stalled.
    task automatic fetch(input logic [31:0] a, input bit fl_hit, input bit fl_miss, input int dly);
        bit          hit;
        int unsigned idx;
        int unsigned tg;
        idx = idx_of(a);
        tg  = tag_of(a);
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        tick();
        req_valid      = 1'b1;
        req_addr       = a;
        flush          = fl_hit;
        mem_resp_valid = 1'b0;
        #1 check_eq("lookup_stall", 32'(stall), 32'(!hit));
        if (hit) begin
            exp_iv    = !fl_hit;
            exp_instr = mem_word(a);
            ref_hits++;
            return;
        end
        ref_misses++;
        exp_mreq  = 1'b1;
        exp_maddr = a - (a % LINE_BYTES);
        tick();
        flush = 1'b0;
        #1 check_eq("req_stall", 32'(stall), 32'd1);
        for (int d = 0; d < dly; d++) begin
            tick();
            flush = fl_miss && (d == 0);
            #1 check_eq("wait_stall", 32'(stall), 32'd1);
        end
        tick();
        flush          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_of(a);
        #1 check_eq("resp_stall", 32'(stall), 32'd1);
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = {LINE_WORDS{32'hBAD0_BAD0}};
        #1 check_eq("fill_stall", 32'(stall), 32'd0);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        exp_iv         = !(fl_hit || fl_miss);
        exp_instr      = mem_word(a);
    endtask

    // Reset while a fill is outstanding, then a stray response.
    task automatic rst_in_wait(input logic [31:0] a);
        tick();
        req_valid = 1'b1;
        req_addr  = a;
        flush     = 1'b0;
        #1 check_eq("rw_lookup_stall", 32'(stall), 32'd1);
        exp_mreq  = 1'b1;
        exp_maddr = a - (a % LINE_BYTES);
        tick();
        #1 check_eq("rw_req_stall", 32'(stall), 32'd1);
        tick();
        #1 check_eq("rw_wait_stall", 32'(stall), 32'd1);
        do_reset();
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = line_of(a);
        #1 check_eq("rw_stray_stall", 32'(stall), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        fetch(a, 1'b0, 1'b0, 1);
    endtask

    initial begin
        logic [31:0] a;
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        flush          = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        exp_iv         = 1'b0;
        exp_mreq       = 1'b0;
        exp_instr      = '0;
        exp_maddr      = '0;
        ref_hits       = 0;
        ref_misses     = 0;
        for (int i = 0; i < NUM_LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end

        do_reset();

        // Boot miss with response 3 cycles after mem_req, then sequential hits.
        fetch(PC_BOOT, 1'b0, 1'b0, 2);
        for (int k = 1; k < 4; k++) fetch(PC_BOOT + 32'(k * 4), 1'b0, 1'b0, 1);
        tick();
        req_valid = 1'b0;
`ifdef ICACHE_STATS_EN
        check_eq("boot_miss_count", miss_count, 32'd1);
        check_eq("boot_hit_count", hit_count, 32'd3);
`endif

        // Conflict: same index, different tag replaces the line.
        fetch(PC_BOOT + 32'(NUM_LINES * LINE_BYTES), 1'b0, 1'b0, 1);
        fetch(PC_BOOT + 32'd4, 1'b0, 1'b0, 3);

        // Flush while waiting for the fill, then re-fetch hits.
        fetch(PC_BOOT + 32'h40, 1'b0, 1'b1, 2);
        fetch(PC_BOOT + 32'h40, 1'b0, 1'b0, 1);
        // Flush on a hit suppresses delivery.
        fetch(PC_BOOT + 32'h44, 1'b1, 1'b0, 1);
        fetch(PC_BOOT + 32'h48, 1'b0, 1'b0, 1);

        // Reset abandons an outstanding fill.
        rst_in_wait(PC_BOOT + 32'h80);

        // Randomized traffic over a few tags per index.
        for (int it = 0; it < 250; it++) begin
            if (it == 125) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                a = PC_BOOT + 32'($urandom_range(0, 4 * NUM_LINES * LINE_WORDS - 1) * 4)
                    + 32'($urandom_range(0, 3));
                fetch(a, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                      int'($urandom_range(1, 4)));
            end
        end
        tick();
        req_valid = 1'b0;
`ifdef ICACHE_STATS_EN
        check_eq("final_hit_count", hit_count, ref_hits);
        check_eq("final_miss_count", miss_count, ref_misses);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, number of direct-mapped lines (power of two, >= 2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a fetch address is presented this cycle.
REQ-006 SHALL have port req_addr, input, ADDRESS_BITS, fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have port flush, input, 1, squash the in-flight fetch (branch redirect).
REQ-008 SHALL have port stall, output, 1, fetch must hold the PC; the fetch enable is driven as NOT stall.
REQ-009 SHALL have port instr_valid, output, 1, instr holds a delivered instruction.
REQ-010 SHALL have port instr, output, REG_LEN, the instruction word.
REQ-011 SHALL have port mem_req, output, 1, line-fill request pulse.
REQ-012 SHALL have port mem_addr, output, ADDRESS_BITS, line-aligned fill address.
REQ-013 SHALL have port mem_resp_valid, input, 1, fill data valid.
REQ-014 SHALL have port mem_resp_data, input, LINE_WORDS*32, full line, word 0 in LSBs.

Function
REQ-015 SHALL split address into tag | index (log2 NUM_LINES) | word offset (log2 LINE_WORDS) | byte [1:0].
REQ-016 SHALL implement FSM states IDLE, MISS_REQ, MISS_WAIT, FILL.
REQ-017 IDLE, req_valid, hit (valid bit set, tag equal): instr/instr_valid registered next cycle (1-cycle latency), stall=0.
REQ-018 IDLE, req_valid, miss: stall=1 combinationally in that cycle; latch address; next state MISS_REQ.
REQ-019 MISS_REQ: mem_req=1 for exactly one cycle, mem_addr = latched address with offset and byte bits zeroed; next MISS_WAIT.
REQ-020 MISS_WAIT: hold until mem_resp_valid; mem_resp_valid outside MISS_WAIT SHALL be ignored.
REQ-021 On mem_resp_valid: write data, tag, valid bit to indexed line; next FILL.
REQ-022 FILL: deliver requested word (instr_valid=1 next cycle), stall=0 in FILL, return to IDLE.
REQ-023 stall SHALL be 1 in every cycle of MISS_REQ and MISS_WAIT and in the IDLE cycle a miss is detected.
REQ-024 flush during IDLE hit: instr_valid SHALL be 0 next cycle.
REQ-025 flush during MISS_REQ/MISS_WAIT: fill SHALL still complete and write the line, but no instruction delivered; FILL returns to IDLE with instr_valid=0.
REQ-026 req_valid=0: no lookup, instr_valid=0 next cycle, stall=0 in IDLE.
REQ-027 A fill to a valid line SHALL overwrite it (replace on conflict).

Reset
REQ-028 rst SHALL clear all valid bits, FSM to IDLE, stall=0, instr_valid=0, instr=0, mem_req=0, mem_addr=0.
REQ-029 rst during MISS_WAIT SHALL abandon the miss; a later mem_resp_valid SHALL be ignored.
REQ-030 rst SHALL take priority over flush, req_valid, mem_resp_valid.

Configuration
REQ-031 With ICACHE_STATS_EN defined: SHALL add outputs hit_count, miss_count (32 bits each, cleared by rst, saturating at all-ones); hit increments on REQ-017, miss on REQ-018.
REQ-032 Without ICACHE_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 After rst, req_addr=PC_BOOT -> miss, stall=1, one mem_req with line-aligned mem_addr; response 3 cycles later -> instr = word (PC_BOOT>>2)%LINE_WORDS, instr_valid for one cycle.
REQ-034 Then sequential addresses PC_BOOT+4..+12 -> hits, stall=0, one instruction per cycle, no mem_req.
REQ-035 Address with same index, different tag -> miss, line replaced; original address re-fetched -> miss again.
REQ-036 flush asserted in MISS_WAIT -> after response instr_valid stays 0; re-request same address -> hit.
REQ-037 rst in MISS_WAIT then stray mem_resp_valid -> ignored, same address misses again.
REQ-038 ICACHE_STATS_EN defined, scenarios REQ-033/034 -> miss_count=1, hit_count=3.
